// File: rtl/board_pkg.sv
// Shared types, timing defaults and helpers for the board button controller.
package board_pkg;

   typedef enum logic [1:0] {BTN_IDLE, BTN_HELD, BTN_LONG} btn_state_e;
   typedef enum logic [1:0] {RST_HOLD, RST_COUNT, RUN} rst_state_e;

   // Default timing for a 25 MHz clk25
   localparam int unsigned DEF_DEBOUNCE_CYCLES   = 250000;
   localparam int unsigned DEF_LONG_PRESS_CYCLES = 25000000;
   localparam int unsigned DEF_POR_CYCLES        = 65536;

   // Width of a counter that must hold values 0..v
   function automatic int cnt_w(input int unsigned v);
      return (v < 1) ? 1 : $clog2(v + 1);
   endfunction

endpackage

// File: rtl/board_button_ctrl_if.sv
// Button pins and cleaned control outputs between board pins and the core.
interface board_button_ctrl_if #(
   parameter int NUM_BTN = 2
);
   logic [NUM_BTN-1:0] btn_in;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic [NUM_BTN-1:0] btn_long;
   logic               sys_rst_n;
   logic               por_done;

   modport master (
      output btn_in,
      input  btn_level, btn_press, btn_release, btn_long, sys_rst_n, por_done
   );

   modport slave (
      input  btn_in,
      output btn_level, btn_press, btn_release, btn_long, sys_rst_n, por_done
   );
endinterface

// File: rtl/board_button_ctrl_btn_debounce.sv
// One button channel: 2-flop synchroniser, polarity fix, debounce counter,
// registered level with press/release pulses aligned to the level change.
module btn_debounce
   import board_pkg::*;
#(
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk25,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic level_nxt,
   output logic press,
   output logic rel
);
   localparam int          CW       = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync0_q, sync0_d, sync1_q, sync1_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d, press_q, press_d, rel_q, rel_d;
   logic          norm;

   always_comb begin
      sync0_d = pin;
      sync1_d = sync0_q;
      norm    = sync1_q ^ ACTIVE_LOW;
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (norm != level_q) begin
         if (cnt_q >= CNT_LAST) begin
            level_d = norm;
            press_d = norm;
            rel_d   = ~norm;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Synchroniser resets to the released pin level so no false edge follows rst
   always_ff @(posedge clk25) begin
      if (rst) begin
         sync0_q <= ACTIVE_LOW;
         sync1_q <= ACTIVE_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync0_q <= sync0_d;
         sync1_q <= sync1_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign level     = level_q;
   assign level_nxt = level_d;
   assign press     = press_q;
   assign rel       = rel_q;

endmodule

// File: rtl/board_button_ctrl.sv
// Debounced buttons with long-press detection and a power-on / reset-button
// sequencer that produces the core's registered active-low reset.
module board_button_ctrl
   import board_pkg::*;
#(
   parameter int          NUM_BTN           = 2,
   parameter bit          BTN_ACTIVE_LOW    = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter int unsigned POR_CYCLES        = DEF_POR_CYCLES,
   parameter bit          RESET_BTN_EN      = 1'b1,
   parameter int          RESET_BTN         = 0
) (
   input logic                clk25,
   input logic                rst,
   board_button_ctrl_if.slave btn
);
   localparam int            HW        = cnt_w(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES);
   localparam int            PW        = cnt_w(POR_CYCLES);
   localparam logic [PW-1:0] POR_LAST  = PW'(POR_CYCLES - 1);

   logic [NUM_BTN-1:0] level, level_nxt, press, rel, rise_nxt, fall_nxt;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .ACTIVE_LOW      (BTN_ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk25     (clk25),
         .rst       (rst),
         .pin       (btn.btn_in[g]),
         .level     (level[g]),
         .level_nxt (level_nxt[g]),
         .press     (press[g]),
         .rel       (rel[g])
      );
   end

   // FSMs follow the debouncer's next level so state changes with btn_level
   assign rise_nxt = level_nxt & ~level;
   assign fall_nxt = ~level_nxt & level;

   btn_state_e                  st_q [NUM_BTN];
   btn_state_e                  st_d [NUM_BTN];
   logic [NUM_BTN-1:0][HW-1:0]  hold_q, hold_d;
   logic [NUM_BTN-1:0]          long_q, long_d;

   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         st_d[i]   = st_q[i];
         hold_d[i] = hold_q[i];
         long_d[i] = 1'b0;
         case (st_q[i])
            BTN_IDLE: if (rise_nxt[i]) begin
               st_d[i]   = BTN_HELD;
               hold_d[i] = HW'(1);
            end
            BTN_HELD: if (fall_nxt[i]) begin
               st_d[i] = BTN_IDLE;
            end else if (hold_q[i] >= HOLD_LAST) begin
               st_d[i]   = BTN_LONG;
               long_d[i] = 1'b1;
            end else begin
               hold_d[i] = hold_q[i] + HW'(1);
            end
            BTN_LONG: if (fall_nxt[i]) st_d[i] = BTN_IDLE;
            default:  st_d[i] = BTN_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         for (int i = 0; i < NUM_BTN; i++) st_q[i] <= BTN_IDLE;
         hold_q <= '0;
         long_q <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) st_q[i] <= st_d[i];
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   rst_state_e    rst_st_q, rst_st_d;
   logic [PW-1:0] por_cnt_q, por_cnt_d;
   logic          sys_rst_n_q, sys_rst_n_d, por_done_q, por_done_d;
   logic          hold_req;

   assign hold_req = RESET_BTN_EN && level_nxt[RESET_BTN];

   // The reset button wins over count completion in every state
   always_comb begin
      rst_st_d    = rst_st_q;
      por_cnt_d   = por_cnt_q;
      sys_rst_n_d = sys_rst_n_q;
      por_done_d  = por_done_q;
      if (hold_req) begin
         rst_st_d    = RST_HOLD;
         por_cnt_d   = '0;
         sys_rst_n_d = 1'b0;
      end else begin
         case (rst_st_q)
            RST_HOLD: begin
               rst_st_d    = RST_COUNT;
               por_cnt_d   = '0;
               sys_rst_n_d = 1'b0;
            end
            RST_COUNT: if (por_cnt_q >= POR_LAST) begin
               rst_st_d    = RUN;
               sys_rst_n_d = 1'b1;
               por_done_d  = 1'b1;
            end else begin
               por_cnt_d   = por_cnt_q + PW'(1);
               sys_rst_n_d = 1'b0;
            end
            RUN:     sys_rst_n_d = 1'b1;
            default: rst_st_d    = RST_COUNT;
         endcase
      end
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         rst_st_q    <= RST_COUNT;
         por_cnt_q   <= '0;
         sys_rst_n_q <= 1'b0;
         por_done_q  <= 1'b0;
      end else begin
         rst_st_q    <= rst_st_d;
         por_cnt_q   <= por_cnt_d;
         sys_rst_n_q <= sys_rst_n_d;
         por_done_q  <= por_done_d;
      end
   end

   assign btn.btn_level   = level;
   assign btn.btn_press   = press;
   assign btn.btn_release = rel;
   assign btn.btn_long    = long_q;
   assign btn.sys_rst_n   = sys_rst_n_q;
   assign btn.por_done    = por_done_q;

endmodule
